// File: rtl/tdm_mux_8x1.sv
// 8-lane round-robin TDM multiplexer: merges eight valid/ready lane streams onto one
// registered output word tagged with its source lane index.
module tdm_mux_8x1 #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [8*WIDTH-1:0]   in_data,
    input  logic [7:0]           in_valid,
    output logic [7:0]           in_ready,
    output logic [WIDTH-1:0]     out_data,
    output logic [2:0]           out_sel,
    output logic                 out_valid,
    input  logic                 out_ready
);

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [2:0]        ptr_q, ptr_d;
    logic [WIDTH-1:0]  data_q, data_d;
    logic [2:0]        sel_q, sel_d;

    logic [WIDTH-1:0]  lane_data [8];
    logic [7:0]        rot_valid;
    logic [2:0]        offset;
    logic [2:0]        grant;
    logic              grant_vld;
    logic              load_en;
    logic              accept;

    // rot_valid[k] is the valid of the lane k positions after the pointer
    for (genvar gi = 0; gi < 8; gi++) begin : g_lane
        assign lane_data[gi] = in_data[gi*WIDTH +: WIDTH];
        assign rot_valid[gi] = in_valid[ptr_q + 3'(gi)];
        assign in_ready[gi]  = !rst && accept && (grant == 3'(gi));
    end

    always_comb begin
        offset = 3'd0;
        for (int k = 7; k >= 0; k--) begin
            if (rot_valid[k]) begin
                offset = 3'(k);
            end
        end
    end

    assign grant     = ptr_q + offset;
    assign grant_vld = |in_valid;
    assign load_en   = (state_q == ST_EMPTY) || out_ready;
    assign accept    = load_en && grant_vld;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        data_d  = data_q;
        sel_d   = sel_q;
        case (state_q)
            ST_EMPTY: begin
                if (accept) begin
                    state_d = ST_FULL;
                    data_d  = lane_data[grant];
                    sel_d   = grant;
                    ptr_d   = grant + 3'd1;
                end
            end
            ST_FULL: begin
                // a draining word may be replaced by a new one in the same cycle
                if (accept) begin
                    data_d  = lane_data[grant];
                    sel_d   = grant;
                    ptr_d   = grant + 3'd1;
                end else if (out_ready) begin
                    state_d = ST_EMPTY;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_EMPTY;
            ptr_q   <= 3'd0;
            data_q  <= '0;
            sel_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            data_q  <= data_d;
            sel_q   <= sel_d;
        end
    end

    assign out_valid = (state_q == ST_FULL);
    assign out_data  = data_q;
    assign out_sel   = sel_q;

endmodule
